// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide sequencer driving an external shared N-bit adder.
// Define MULDIV_SEQ_DIV_EN to build the DIVU/REMU path; otherwise divide ops return out_err.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// MUL   | shift-add iterations, one multiplier bit per cycle
// DIV   | restoring-divide iterations, one quotient bit per cycle
// DONE  | result held until out_ready
module muldiv_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] opa,
    input  logic [N-1:0] opb,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N:0]   add_out,
    output logic         out_valid,
    output logic [N-1:0] result,
    output logic         out_err,
    input  logic         out_ready
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MULDIV_SEQ_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    // acc: product high half / remainder; sh: multiplier->product low half / dividend->quotient
    logic [N-1:0]  acc;
    logic [N-1:0]  sh;
    logic [N-1:0]  src;
    logic          sel_hi;
    logic          err;
    logic          last;

    assign last = (cnt == CW'(N - 1));

`ifdef MULDIV_SEQ_DIV_EN
    logic [N-1:0] shifted;
    logic         take;

    assign shifted = {acc[N-2:0], sh[N-1]};
    // A remainder MSB shifted out of the N-bit adder means the true value exceeds the divisor.
    assign take    = add_out[N] | acc[N-1];
`endif

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            S_MUL: begin
                add_a = acc;
                add_b = sh[0] ? src : '0;
            end
`ifdef MULDIV_SEQ_DIV_EN
            S_DIV: begin
                add_a   = shifted;
                add_b   = src;
                add_cin = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            sh     <= '0;
            src    <= '0;
            sel_hi <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sel_hi <= op[0];
                        cnt    <= '0;
                        acc    <= '0;
`ifdef MULDIV_SEQ_DIV_EN
                        sh     <= op[1] ? opa : opb;
                        src    <= op[1] ? opb : opa;
                        err    <= 1'b0;
                        state  <= op[1] ? S_DIV : S_MUL;
`else
                        sh     <= opb;
                        src    <= opa;
                        err    <= op[1];
                        state  <= op[1] ? S_DONE : S_MUL;
`endif
                    end
                end
                S_MUL: begin
                    acc <= add_out[N:1];
                    sh  <= {add_out[0], sh[N-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last) state <= S_DONE;
                end
`ifdef MULDIV_SEQ_DIV_EN
                S_DIV: begin
                    acc <= take ? add_out[N-1:0] : shifted;
                    sh  <= {sh[N-2:0], take};
                    cnt <= cnt + CW'(1);
                    if (last) state <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_err   = out_valid & err;
    assign result    = (out_valid && !err) ? (sel_hi ? acc : sh) : '0;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: external adder, arithmetic reference model, directed ops.
// Expectations follow MULDIV_SEQ_DIV_EN the same way the design does.
module tb_muldiv_sequencer;

    localparam int N = 32;
`ifdef MULDIV_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] opa = '0;
    logic [N-1:0] opb = '0;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N:0]   add_out;
    logic         out_valid;
    logic [N-1:0] result;
    logic         out_err;
    logic         out_ready = 1'b0;

    int checks = 0;
    int fails  = 0;

    muldiv_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .opa(opa), .opb(opb),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_out(add_out),
        .out_valid(out_valid), .result(result), .out_err(out_err), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // shared ripple-carry adder: b is inverted when cin=1
    assign add_out = {1'b0, add_a} + {1'b0, (add_cin ? ~add_b : add_b)} + {{N{1'b0}}, add_cin};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model: arithmetic results plus busy/done timing
    logic [N-1:0] m_res = '0;
    logic         m_err = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           m_div = 1'b0;
    int           m_left = 0;
    bit           mon_en = 1'b0;

    always @(posedge clk) begin
        logic [2*N-1:0] prod;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (in_valid) begin
            prod  = {{N{1'b0}}, opa} * {{N{1'b0}}, opb};
            m_err = 1'b0;
            case (op)
                2'b00: m_res = prod[N-1:0];
                2'b01: m_res = prod[2*N-1:N];
                2'b10: m_res = (opb == 0) ? '1 : opa / opb;
                default: m_res = (opb == 0) ? opa : opa % opb;
            endcase
            m_div = op[1];
            if (op[1] && !DIV_EN) begin
                m_res  = '0;
                m_err  = 1'b1;
                m_done = 1'b1;
            end else begin
                m_busy = 1'b1;
                m_left = N;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon in_ready", in_ready, !m_busy && !m_done);
            chk("mon out_valid", out_valid, m_done);
            if (m_done) begin
                chk("mon result", result, m_res);
                chk("mon out_err", out_err, m_err);
            end
            if (m_busy) begin
                chk("mon add_cin", add_cin, m_div);
            end else begin
                chk("mon add_a idle", add_a, 0);
                chk("mon add_b idle", add_b, 0);
                chk("mon add_cin idle", add_cin, 0);
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_in, input int hold, input string name);
        logic [N-1:0] exp_r;
        logic         exp_e;
        int           exp_t;
        int           t;
        exp_r = exp_in;
        exp_e = 1'b0;
        exp_t = N + 1;
        if (o[1] && !DIV_EN) begin
            exp_r = '0;
            exp_e = 1'b1;
            exp_t = 1;
        end
        in_valid = 1'b1; op = o; opa = a; opb = b;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            if (!out_valid) begin
                in_valid = 1'($urandom);
                op  = 2'($urandom);
                opa = $urandom;
                opb = $urandom;
            end
        end while (!out_valid && t < N + 10);
        in_valid = 1'b0;
        chk({name, " latency"}, t, exp_t);
        chk({name, " result"}, result, exp_r);
        chk({name, " out_err"}, out_err, exp_e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " stall result"}, result, exp_r);
            chk({name, " stall out_valid"}, out_valid, 1);
            chk({name, " stall in_ready"}, in_ready, 0);
        end
        // request offered during hand-off must not be taken
        out_ready = 1'b1; in_valid = 1'b1; op = 2'b00; opa = 3; opb = 3;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk({name, " handoff in_ready"}, in_ready, 1);
        chk({name, " handoff out_valid"}, out_valid, 0);
    endtask

    task automatic abort_test();
        int seen;
        in_valid = 1'b1; op = DIV_EN ? 2'b10 : 2'b00; opa = 100; opb = 7;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready", in_ready, 1);
        chk("abort out_valid", out_valid, 0);
        seen = 0;
        repeat (N + 10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort no result", seen, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset out_err", out_err, 0);
        chk("reset add_cin", add_cin, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'd7, 32'd6, 32'd42, 10, "mul_7x6");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_max");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, "mul_max");
        run_op(2'b01, 32'h8000_0000, 32'd4, 32'd2, 0, "mulhu_2p33");
        run_op(2'b00, 32'h8000_0000, 32'd4, 32'd0, 0, "mul_2p33");
        run_op(2'b10, 32'd100, 32'd7, 32'd14, 2, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 0, "remu_100_7");
        run_op(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "divu_by0");
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 0, "remu_by0");
        run_op(2'b10, 32'd9, 32'd3, 32'd3, 0, "divu_9_3");
        run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 0, "divu_bigdiv");
        run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 0, "remu_bigdiv");
        run_op(2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "remu_lt");

        abort_test();
        run_op(2'b00, 32'd3, 32'd5, 32'd15, 0, "post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand width and the shared adder width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning a request is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning a request can be accepted.
REQ-006 The block SHALL have port op, input, 2 bits, with encoding 00 MUL (low product), 01 MULHU (high product), 10 DIVU, 11 REMU.
REQ-007 The block SHALL have ports opa and opb, input, N bits each: multiplicand/dividend and multiplier/divisor.
REQ-008 The block SHALL have ports add_a and add_b, output, N bits each, and add_cin, output, 1 bit, driving the shared ripple-carry adder (cin=1 selects a-b, since the adder inverts b by cin).
REQ-009 The block SHALL have port add_out, input, N+1 bits, the adder result {carry, sum}.
REQ-010 The block SHALL have ports out_valid, output, 1 bit; result, output, N bits; out_err, output, 1 bit; and out_ready, input, 1 bit.

Function
REQ-011 The block SHALL implement FSM states IDLE, MUL, DIV, DONE, plus an iteration counter of ceil(log2(N))+1 bits.
REQ-012 in_ready SHALL equal (state==IDLE); a request SHALL be accepted on a cycle with in_valid and in_ready both high; op, opa and opb SHALL be latched, the counter cleared, and the FSM moved to MUL (op[1]=0) or DIV (op[1]=1).
REQ-013 MUL state: each cycle, add_a = hi accumulator, add_b = multiplicand if multiplier LSB is 1 else 0, add_cin = 0; {add_out, lo} SHALL shift right one bit into {hi, lo}.
REQ-014 DIV state: each cycle, the remainder SHALL be shifted left taking the dividend MSB, with add_a = shifted remainder, add_b = divisor, add_cin = 1; if add_out[N]=1 (no borrow), the remainder SHALL take add_out[N-1:0] and quotient bit 1, else the remainder is kept and quotient bit 0.
REQ-015 Exactly N iteration cycles SHALL follow acceptance; with acceptance at cycle T, out_valid SHALL rise at T+N+1.
REQ-016 DONE: out_valid=1, result stable (MUL low N bits, MULHU high N bits, DIVU quotient, REMU remainder), out_err=0; on out_ready=1 the FSM SHALL go to IDLE next cycle. A new request SHALL not be accepted in the same cycle as the result hand-off.
REQ-017 Divide by zero SHALL yield quotient all ones and remainder = opa with out_err=0, falling naturally out of REQ-014.
REQ-018 in_valid while not IDLE SHALL be ignored without latching; inputs may change freely while busy.
REQ-019 Outside MUL/DIV, add_a, add_b and add_cin SHALL be driven to 0.
REQ-020 The multiplication product SHALL be the full 2N-bit unsigned product; no sign handling.

Reset
REQ-021 rst=1 SHALL force IDLE, clear counter and datapath registers, and drive in_ready=1, out_valid=0, result=0, out_err=0 on the next edge.
REQ-022 rst during MUL, DIV or DONE SHALL abort the operation with no result ever presented.

Configuration
REQ-023 With macro MULDIV_SEQ_DIV_EN defined, DIVU and REMU SHALL operate per REQ-014..017.
REQ-024 Without MULDIV_SEQ_DIV_EN, the DIV state and its datapath SHALL be absent; op[1]=1 SHALL go directly to DONE at T+1 with result=0 and out_err=1; MUL behaviour is unchanged.

Verification
REQ-025 MUL opa=7, opb=6 -> out_valid at T+33, result=42, out_err=0.
REQ-026 MULHU opa=0xFFFFFFFF, opb=0xFFFFFFFF -> result=0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-027 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-028 out_ready held low 10 cycles after DONE -> out_valid and result stable, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-029 rst asserted at T+10 of a DIVU -> in_ready=1 and out_valid=0 next cycle; no result ever appears.
REQ-030 Build without MULDIV_SEQ_DIV_EN, DIVU 9/3 -> out_valid at T+1, result=0, out_err=1.
